// File: rtl/lvt_read_mux.sv
// lvt_read_mux: live-value table and read select for a multi-write, single-read RAM
// Tracks the last writing agent of each address and picks that agent's bank copy
// when a read completes.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   wren, wraddr             per-agent write enable/address (same as the banks see)
//   rden, rdaddr             read request
//   bank_rden, bank_rdaddr   read request fanned out to every bank
//   bank_rddata              bank read data, one cycle after bank_rden
//   rdvalid, rddata          read result
// Optional: define LVT_OUTREG_EN to register rddata/rdvalid one more stage (latency 2).
module lvt_read_mux #(
  parameter int NB_WRAGENT = 2,
  parameter int ADDR_WIDTH = 8,
  parameter int RAM_DEPTH  = 2**ADDR_WIDTH,
  parameter int DATA_WIDTH = 32,
  localparam int SEL_WIDTH = (NB_WRAGENT > 1) ? $clog2(NB_WRAGENT) : 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NB_WRAGENT-1:0]            wren,
  input  logic [ADDR_WIDTH*NB_WRAGENT-1:0] wraddr,
  input  logic                             rden,
  input  logic [ADDR_WIDTH-1:0]            rdaddr,
  output logic [NB_WRAGENT-1:0]            bank_rden,
  output logic [ADDR_WIDTH*NB_WRAGENT-1:0] bank_rdaddr,
  input  logic [DATA_WIDTH*NB_WRAGENT-1:0] bank_rddata,
  output logic                             rdvalid,
  output logic [DATA_WIDTH-1:0]            rddata
);
  logic [SEL_WIDTH-1:0]  lvt_q [RAM_DEPTH];
  logic [SEL_WIDTH-1:0]  sel_d, sel_q;
  logic                  vld_q;
  logic [DATA_WIDTH-1:0] mux, hold_q;
  assign bank_rden   = {NB_WRAGENT{rden}};
  assign bank_rdaddr = {NB_WRAGENT{rdaddr}};
  // Ascending loop: a later (higher-index) agent's assignment wins on collision.
  always_ff @(posedge clk or posedge rst)
    if (rst)
      for (int k = 0; k < RAM_DEPTH; k++) lvt_q[k] <= '0;
    else
      for (int i = 0; i < NB_WRAGENT; i++)
        if (wren[i] && int'(wraddr[ADDR_WIDTH*i +: ADDR_WIDTH]) < RAM_DEPTH)
          lvt_q[wraddr[ADDR_WIDTH*i +: ADDR_WIDTH]] <= SEL_WIDTH'(i);
  assign sel_d = (int'(rdaddr) < RAM_DEPTH) ? lvt_q[rdaddr] : '0;
  assign mux   = bank_rddata[DATA_WIDTH*sel_q +: DATA_WIDTH];
  // hold_q keeps the last delivered word so rddata is stable while idle.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sel_q  <= '0;
      vld_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      vld_q <= rden;
      if (rden) sel_q <= sel_d;
      if (vld_q) hold_q <= mux;
    end
`ifdef LVT_OUTREG_EN
  logic ovld_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) ovld_q <= 1'b0;
    else ovld_q <= vld_q;
  assign rdvalid = ovld_q;
  assign rddata  = hold_q;
`else
  assign rdvalid = vld_q;
  assign rddata  = vld_q ? mux : hold_q;
`endif
endmodule

// File: tb/tb_lvt_read_mux.sv
// tb_lvt_read_mux: scoreboard bench for lvt_read_mux with a last-writer-wins memory model
module tb_lvt_read_mux;
  localparam int NB = 2, AW = 8, DW = 32;
`ifdef LVT_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  typedef struct {logic [DW-1:0] d; int due;} exp_t;
  logic clk = 0, rst = 1;
  logic [NB-1:0] wren = '0;
  logic [AW*NB-1:0] wraddr = '0;
  logic rden = 0;
  logic [AW-1:0] rdaddr = '0;
  logic [NB-1:0] bank_rden;
  logic [AW*NB-1:0] bank_rdaddr;
  logic [DW*NB-1:0] bank_rddata;
  logic rdvalid;
  logic [DW-1:0] rddata;
  logic [DW*NB-1:0] wd_r = '0;
  logic [DW-1:0] bmem [NB][256];
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] last_exp = '0;
  logic inited = 0;
  exp_t q[$];
  int cyc = 0, tests = 0, fails = 0;

  lvt_read_mux dut (
    .clk(clk), .rst(rst), .wren(wren), .wraddr(wraddr), .rden(rden), .rdaddr(rdaddr),
    .bank_rden(bank_rden), .bank_rdaddr(bank_rdaddr), .bank_rddata(bank_rddata),
    .rdvalid(rdvalid), .rddata(rddata));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [DW-1:0] init_val(int b, int a);
    return (b == 0 ? 32'hAAAA0000 : 32'h5555FFFF) ^ (32'(a ^ 'h10) << 8);
  endfunction

  // Read-first bank array: each bank holds only its own agent's writes.
  always @(posedge clk) begin
    if (!inited) begin
      for (int b = 0; b < NB; b++)
        for (int a = 0; a < 256; a++) bmem[b][a] <= init_val(b, a);
      inited <= 1;
    end else
      for (int b = 0; b < NB; b++) begin
        if (bank_rden[b]) bank_rddata[DW*b +: DW] <= bmem[b][bank_rdaddr[AW*b +: AW]];
        if (wren[b]) bmem[b][wraddr[AW*b +: AW]] <= wd_r[DW*b +: DW];
      end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (rdvalid) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL spurious_valid: rdvalid=1 rddata=%h at cycle %0d, no read pending", rddata, cyc);
        end else begin
          e = q.pop_front();
          if (rddata !== e.d || cyc != e.due) begin
            fails++;
            $display("FAIL read_data: got %h at cycle %0d, expected %h at cycle %0d", rddata, cyc, e.d, e.due);
          end
          last_exp = e.d;
        end
      end else begin
        tests++;
        if (rddata !== last_exp) begin
          fails++;
          $display("FAIL hold: rddata=%h while idle, expected %h", rddata, last_exp);
        end
        if (q.size() != 0 && cyc >= q[0].due) begin
          tests++;
          fails++;
          $display("FAIL missing_valid: rdvalid=0 at cycle %0d, expected %h due at %0d", cyc, q[0].d, q[0].due);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step(input logic [NB-1:0] we, input logic [AW*NB-1:0] wa,
                      input logic [DW*NB-1:0] wd, input logic re, input logic [AW-1:0] ra);
    @(posedge clk);
    #1;
    wren = we; wraddr = wa; wd_r = wd; rden = re; rdaddr = ra;
    if (re) q.push_back('{ref_mem[ra], cyc + LAT});
    for (int i = 0; i < NB; i++) if (we[i]) ref_mem[wa[AW*i +: AW]] = wd[DW*i +: DW];
    #1;
    tests++;
    if (bank_rden !== {NB{re}} || bank_rdaddr !== {NB{ra}}) begin
      fails++;
      $display("FAIL fanout: bank_rden=%b bank_rdaddr=%h, expected %b %h", bank_rden, bank_rdaddr, {NB{re}}, {NB{ra}});
    end
  endtask

  task automatic check_reset_out(input string tag);
    tests += 2;
    if (rdvalid !== 1'b0) begin fails++; $display("FAIL %s_rdvalid: got %b expected 0", tag, rdvalid); end
    if (rddata !== '0) begin fails++; $display("FAIL %s_rddata: got %h expected 0", tag, rddata); end
  endtask

  initial begin
    logic [AW-1:0] a0, a1;
    for (int a = 0; a < 256; a++) ref_mem[a] = init_val(0, a);
    repeat (2) @(posedge clk);
    #1 check_reset_out("reset");
    @(posedge clk);
    #3 rst = 0;
    step(2'b00, '0, '0, 1, 8'h10);
    step(2'b10, {8'h10, 8'h00}, {32'h5555FFFF, 32'h0}, 0, 0);
    step(2'b00, '0, '0, 0, 0);
    step(2'b00, '0, '0, 1, 8'h10);
    step(2'b11, {8'h20, 8'h20}, {32'h22222222, 32'h11111111}, 0, 0);
    step(2'b00, '0, '0, 1, 8'h20);
    step(2'b10, {8'h30, 8'h00}, {32'h33333333, 32'h0}, 1, 8'h30);
    step(2'b00, '0, '0, 1, 8'h30);
    step(2'b00, '0, '0, 1, 8'h10);
    step(2'b00, '0, '0, 1, 8'h20);
    step(2'b00, '0, '0, 1, 8'h30);
    repeat (4) step(2'b00, '0, '0, 0, 0);
    // Reset with a read in flight: output must drop at once and the read vanish.
    step(2'b00, '0, '0, 1, 8'h10);
    @(posedge clk);
    #2 rst = 1;
    #1 check_reset_out("midread_reset");
    q.delete();
    last_exp = '0;
    rden = 0;
    for (int a = 0; a < 256; a++) ref_mem[a] = bmem[0][a];
    repeat (2) @(posedge clk);
    #3 rst = 0;
    repeat (3) step(2'b00, '0, '0, 0, 0);
    step(2'b00, '0, '0, 1, 8'h10);
    step(2'b00, '0, '0, 1, 8'h20);
    repeat (3) step(2'b00, '0, '0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      a0 = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 15)) : AW'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom_range(0, 15));
      step(NB'($urandom), {a1, a0}, {32'($urandom), 32'($urandom)},
           $urandom_range(0, 9) < 7, ($urandom_range(0, 1) == 1) ? a0 : AW'($urandom_range(0, 15)));
    end
    repeat (5) step(2'b00, '0, '0, 0, 0);
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: %0d reads never returned, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
